// File: rtl/key_expansion_engine_multimode.sv
// AES-128/192/256 key schedule engine: one 32-bit word per cycle into a word store, round keys read by index.
// Latency: o_done pulses 41/47/53 cycles after the accepted start; round-key reads are combinational.
// Backpressure: none; i_start is dropped while busy, reserved-mode starts only pulse o_mode_err.

module subbytes_block #(
    parameter int N_BYTES = 4
) (
    input  logic [8*N_BYTES-1:0] i_state,
    output logic [8*N_BYTES-1:0] o_state
);
    // AES S-box, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    for (genvar b = 0; b < N_BYTES; b++) begin : g_byte
        logic [10:0] base;
        assign base = 11'd2047 - {i_state[8*b +: 8], 3'b000};
        assign o_state[8*b +: 8] = SBOX[base -: 8];
    end
endmodule

module key_expansion_engine_multimode #(
    parameter int NB_BYTE       = 8,
    parameter int N_BYTES_WORD  = 4,
    parameter int NB_WORD       = N_BYTES_WORD*NB_BYTE,
    parameter int N_BYTES_STATE = 16,
    parameter int MAX_ROUNDS    = 14,
    parameter int NB_ROUND_IDX  = 4,
    parameter int NB_KEY        = 256
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_start,
    input  logic [1:0]                         i_key_mode,
    input  logic [NB_KEY-1:0]                  i_key,
    input  logic [NB_ROUND_IDX-1:0]            i_round_idx,
    output logic                               o_busy,
    output logic                               o_done,
    output logic                               o_key_valid,
    output logic                               o_mode_err,
    output logic [NB_ROUND_IDX-1:0]            o_n_rounds,
    output logic [N_BYTES_STATE*NB_BYTE-1:0]   o_round_key
);
    localparam int NW_MAX = 4*(MAX_ROUNDS+1);
    localparam int NB_IDX = $clog2(NW_MAX);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [NB_WORD-1:0]  w_q [NW_MAX];
    logic [NB_WORD-1:0]  w_d [NW_MAX];
    logic [NB_IDX-1:0]   i_q, i_d;
    logic [2:0]          phase_q, phase_d;
    logic [7:0]          rcon_q, rcon_d;
    logic [1:0]          mode_q, mode_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [NB_IDX-1:0]       nk, nw_last, start_nk;
    logic [2:0]              phase_last;
    logic [NB_ROUND_IDX-1:0] nr;
    logic [NB_WORD-1:0]      w_prev, w_back, sub_in, sub_out, temp, new_word;
    logic [7:0]              rcon_x;
    logic                    can_start, start_ok, start_bad;
    logic                    key_valid, rd_ok;
    logic [NB_ROUND_IDX-1:0] rd_idx;
    logic [NB_IDX-1:0]       rd_base;

    always_comb begin
        nk = NB_IDX'(4); nr = NB_ROUND_IDX'(10); nw_last = NB_IDX'(43); phase_last = 3'd3;
        case (mode_q)
            2'd1:    begin nk = NB_IDX'(6); nr = NB_ROUND_IDX'(12); nw_last = NB_IDX'(51); phase_last = 3'd5; end
            2'd2:    begin nk = NB_IDX'(8); nr = NB_ROUND_IDX'(14); nw_last = NB_IDX'(59); phase_last = 3'd7; end
            default: ;
        endcase
    end

    assign start_nk  = (i_key_mode == 2'd1) ? NB_IDX'(6) :
                       (i_key_mode == 2'd2) ? NB_IDX'(8) : NB_IDX'(4);
    assign can_start = i_start && (state_q != S_EXPAND);
    assign start_ok  = can_start && (i_key_mode != 2'd3);
    assign start_bad = can_start && (i_key_mode == 2'd3);

    // phase_q tracks i mod NK, so no divider is needed to spot the Rcon/SubWord slots
    assign w_prev   = w_q[i_q - NB_IDX'(1)];
    assign w_back   = w_q[i_q - nk];
    assign sub_in   = (phase_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign rcon_x   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    assign new_word = w_back ^ temp;

    subbytes_block #(.N_BYTES(N_BYTES_WORD)) u_subword (
        .i_state (sub_in),
        .o_state (sub_out)
    );

    always_comb begin
        temp = w_prev;
        if (phase_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (mode_q == 2'd2 && phase_q == 3'd4) begin
            temp = sub_out;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        phase_d = phase_q;
        rcon_d  = rcon_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = start_bad;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    for (int j = 0; j < NB_KEY/NB_WORD; j++) begin
                        w_d[j] = i_key[NB_KEY-1-NB_WORD*j -: NB_WORD];
                    end
                    mode_d  = i_key_mode;
                    i_d     = start_nk;
                    phase_d = 3'd0;
                    rcon_d  = 8'h01;
                    state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + NB_IDX'(1);
                phase_d  = (phase_q == phase_last) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) begin
                    rcon_d = rcon_x;
                end
                if (i_q == nw_last) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            phase_q <= '0;
            rcon_q  <= 8'h01;
            mode_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            phase_q <= phase_d;
            rcon_q  <= rcon_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Store contents are don't-care until o_key_valid, so no reset
    always_ff @(posedge i_clock) begin
        w_q <= w_d;
    end

    assign key_valid   = (state_q == S_DONE);
    assign rd_ok       = key_valid && (i_round_idx <= nr);
    assign rd_idx      = rd_ok ? i_round_idx : '0;
    assign rd_base     = NB_IDX'({rd_idx, 2'b00});
    assign o_round_key = rd_ok ? {w_q[rd_base], w_q[rd_base + NB_IDX'(1)],
                                  w_q[rd_base + NB_IDX'(2)], w_q[rd_base + NB_IDX'(3)]} : '0;
    assign o_busy      = (state_q == S_EXPAND);
    assign o_done      = done_q;
    assign o_key_valid = key_valid;
    assign o_mode_err  = err_q;
    assign o_n_rounds  = key_valid ? nr : '0;

endmodule
